lc3b_branch_predictor: RTL and testbench

- Parametrised direct-mapped branch target buffer (BTB) with saturating direction counters for the LC-3b pipeline.
- Replaces the fixed predict-not-taken fetch. Flush on mismatch stays in the datapath.
- Fetch stage looks up the current PC combinationally and gets a predicted next PC.
- MEM stage, where branch and jump resolution happens, writes back the resolved outcome one update per cycle.

---
 rtl/lc3b_branch_predictor_if.sv | 32 +++
 rtl/lc3b_branch_predictor.sv | 96 +++++++++
 tb/tb_lc3b_branch_predictor.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_branch_predictor_if.sv
// Fetch/MEM-side bundle for the LC-3b branch predictor: lookup, resolved-update
// and statistics signals. The master is the datapath; the slave is the predictor.
interface lc3b_branch_predictor_if #(
   parameter int WORD_W = 16,
   parameter int STAT_W = 16
);
   logic              lookup_valid;
   logic [WORD_W-1:0] lookup_pc;
   logic              hit;
   logic              predict_taken;
   logic [WORD_W-1:0] predict_target;
   logic              update_valid;
   logic [WORD_W-1:0] update_pc;
   logic              update_taken;
   logic [WORD_W-1:0] update_target;
   logic              update_mispredict;
   logic              invalidate_all;
   logic [STAT_W-1:0] lookup_count;
   logic [STAT_W-1:0] mispredict_count;

   modport master (
      output lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
             update_target, update_mispredict, invalidate_all,
      input  hit, predict_taken, predict_target, lookup_count, mispredict_count
   );

   modport slave (
      input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
             update_target, update_mispredict, invalidate_all,
      output hit, predict_taken, predict_target, lookup_count, mispredict_count
   );
endinterface

// File: rtl/lc3b_branch_predictor.sv
// Direct-mapped BTB with saturating direction counters. Fetch reads it
// combinationally; MEM writes one resolved outcome per cycle.
module lc3b_branch_predictor #(
   parameter int ENTRIES  = 16,
   parameter int WORD_W   = 16,
   parameter int CTR_BITS = 2,
   parameter int STAT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   lc3b_branch_predictor_if.slave    bp
);
   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = WORD_W - IDX - 1;
   localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

   logic [ENTRIES-1:0]  r_valid;
   logic [TAG_W-1:0]    r_tag    [ENTRIES];
   logic [WORD_W-1:0]   r_target [ENTRIES];
   logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
   logic [STAT_W-1:0]   r_lookup_count;
   logic [STAT_W-1:0]   r_mispredict_count;

   logic [IDX-1:0]   w_lk_idx;
   logic [TAG_W-1:0] w_lk_tag;
   logic [IDX-1:0]   w_up_idx;
   logic [TAG_W-1:0] w_up_tag;
   logic             w_up_hit;

   assign w_lk_idx = bp.lookup_pc[IDX:1];
   assign w_lk_tag = bp.lookup_pc[WORD_W-1:IDX+1];
   assign w_up_idx = bp.update_pc[IDX:1];
   assign w_up_tag = bp.update_pc[WORD_W-1:IDX+1];
   assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

   // Lookup sees only registered state, so a same-cycle update is not bypassed.
   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      bp.hit            = 1'b0;
      bp.predict_taken  = 1'b0;
      bp.predict_target = bp.lookup_pc + WORD_W'(2);
      if (bp.lookup_valid && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag)) begin
         bp.hit = 1'b1;
         if (r_ctr[w_lk_idx][CTR_BITS-1]) begin
            bp.predict_taken  = 1'b1;
            bp.predict_target = r_target[w_lk_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         // NOTE: the entry arrays are cleared on reset on purpose; this keeps them in flops rather than RAM.
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= '0;
         end
      end else if (bp.invalidate_all) begin
         r_valid <= '0;
      end else if (bp.update_valid) begin
         if (w_up_hit) begin
            if (bp.update_taken) begin
               // NOTE: non-blocking assignments for all state so every read sees the pre-edge value.
               if (r_ctr[w_up_idx] != CTR_MAX) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + CTR_BITS'(1);
               r_target[w_up_idx] <= bp.update_target;
            end else if (r_ctr[w_up_idx] != '0) begin
               r_ctr[w_up_idx] <= r_ctr[w_up_idx] - CTR_BITS'(1);
            end
         end else if (bp.update_taken) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= bp.update_target;
            r_ctr[w_up_idx]    <= CTR_WEAK;
         end
      end
   end

   // Statistics saturate rather than wrap and ignore invalidate_all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lookup_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         if (bp.lookup_valid && (r_lookup_count != '1))
            r_lookup_count <= r_lookup_count + STAT_W'(1);
         if (bp.update_valid && bp.update_mispredict && (r_mispredict_count != '1))
            r_mispredict_count <= r_mispredict_count + STAT_W'(1);
      end
   end

   assign bp.lookup_count     = r_lookup_count;
   assign bp.mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_lc3b_branch_predictor.sv
// Directed bench for lc3b_branch_predictor: a table-based BTB model is compared
// against the DUT every cycle, plus hand-computed literal checks.
module tb_lc3b_branch_predictor;
   localparam int ENTRIES = 16;
   localparam int WORD_W  = 16;
   localparam int STAT_W  = 4;
   localparam int IDX     = 4;
   localparam int STAT_MAX = 15;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   bit   chk_en;

   lc3b_branch_predictor_if #(.WORD_W(WORD_W), .STAT_W(STAT_W)) bp ();

   lc3b_branch_predictor #(
      .ENTRIES(ENTRIES), .WORD_W(WORD_W), .CTR_BITS(2), .STAT_W(STAT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bp    (bp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: one table slot per index, counter kept as a plain integer 0..3.
   bit m_valid  [ENTRIES];
   int m_tag    [ENTRIES];
   int m_target [ENTRIES];
   int m_ctr    [ENTRIES];
   int m_lookups;
   int m_mispredicts;

   function automatic int idx_of(input int pc);
      return (pc / 2) % ENTRIES;
   endfunction

   function automatic int tag_of(input int pc);
      return pc / (2 * ENTRIES);
   endfunction

   function automatic bit m_present(input int pc);
      return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   function automatic bit m_taken(input int pc);
      return m_present(pc) && (m_ctr[idx_of(pc)] >= 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
      end
      m_lookups = 0;
      m_mispredicts = 0;
   endtask

   task automatic model_edge();
      int i;
      if (!rst_n) return;
      if (bp.lookup_valid && m_lookups < STAT_MAX) m_lookups++;
      if (bp.update_valid && bp.update_mispredict && m_mispredicts < STAT_MAX) m_mispredicts++;
      i = idx_of(int'(bp.update_pc));
      if (bp.invalidate_all) begin
         for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
      end else if (bp.update_valid) begin
         if (m_present(int'(bp.update_pc))) begin
            if (bp.update_taken) begin
               if (m_ctr[i] < 3) m_ctr[i]++;
               m_target[i] = int'(bp.update_target);
            end else if (m_ctr[i] > 0) begin
               m_ctr[i]--;
            end
         end else if (bp.update_taken) begin
            m_valid[i]  = 1;
            m_tag[i]    = tag_of(int'(bp.update_pc));
            m_target[i] = int'(bp.update_target);
            m_ctr[i]    = 2;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      int pc;
      bit e_hit, e_pt;
      int e_tgt;
      pc    = int'(bp.lookup_pc);
      e_hit = bp.lookup_valid && m_present(pc);
      e_pt  = bp.lookup_valid && m_taken(pc);
      e_tgt = e_pt ? m_target[idx_of(pc)] : ((pc + 2) % 65536);
      check({tag, ".hit"}, 32'(bp.hit), 32'(e_hit));
      check({tag, ".taken"}, 32'(bp.predict_taken), 32'(e_pt));
      check({tag, ".target"}, 32'(bp.predict_target), 32'(e_tgt));
      check({tag, ".lookup_count"}, 32'(bp.lookup_count), 32'(m_lookups));
      check({tag, ".mispredict_count"}, 32'(bp.mispredict_count), 32'(m_mispredicts));
   endtask

   always @(negedge clk) if (chk_en) compare_all("cyc");

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      bp.lookup_valid = 0; bp.lookup_pc = '0;
      bp.update_valid = 0; bp.update_pc = '0; bp.update_taken = 0;
      bp.update_target = '0; bp.update_mispredict = 0; bp.invalidate_all = 0;
   endtask

   task automatic lookup(input logic [15:0] pc);
      idle();
      bp.lookup_valid = 1; bp.lookup_pc = pc;
   endtask

   task automatic update(input logic [15:0] pc, input bit taken, input logic [15:0] tgt);
      idle();
      bp.update_valid = 1; bp.update_pc = pc; bp.update_taken = taken; bp.update_target = tgt;
   endtask

   task automatic probe(input string name, input bit e_hit, input bit e_pt, input logic [15:0] e_tgt);
      #1;
      check({name, ".hit"}, 32'(bp.hit), 32'(e_hit));
      check({name, ".taken"}, 32'(bp.predict_taken), 32'(e_pt));
      check({name, ".target"}, 32'(bp.predict_target), 32'(e_tgt));
   endtask

   initial begin
      n_vec = 0; n_err = 0; chk_en = 0;
      rst_n = 0;
      idle();
      model_reset();
      chk_en = 1;
      #12 rst_n = 1;
      tick();

      // Cold lookup misses and falls through to pc+2.
      lookup(16'h3000);
      probe("cold", 0, 0, 16'h3002);
      tick();
      idle();
      #1 check("lookup_count_after_one", 32'(bp.lookup_count), 32'd1);

      // Allocate weakly taken.
      update(16'h3010, 1, 16'h3100); tick();
      lookup(16'h3010); probe("alloc", 1, 1, 16'h3100); tick();

      // Down to strongly not-taken, then hold at zero.
      update(16'h3010, 0, 16'h0); tick();
      update(16'h3010, 0, 16'h0); tick();
      lookup(16'h3010); probe("ctr00", 1, 0, 16'h3012); tick();
      for (int k = 0; k < 3; k++) begin update(16'h3010, 0, 16'h0); tick(); end
      update(16'h3010, 1, 16'h3100); tick();
      update(16'h3010, 1, 16'h3100); tick();
      lookup(16'h3010); probe("floor_then_two_taken", 1, 1, 16'h3100); tick();
      update(16'h3010, 1, 16'h3100); tick();
      update(16'h3010, 1, 16'h3100); tick();
      update(16'h3010, 0, 16'h0); tick();
      lookup(16'h3010); probe("ceiling_then_nt", 1, 1, 16'h3100); tick();

      // Alias at index 8 evicts the resident entry.
      update(16'h3030, 1, 16'h4000); tick();
      lookup(16'h3010); probe("evicted", 0, 0, 16'h3012); tick();
      lookup(16'h3030); probe("alias", 1, 1, 16'h4000); tick();

      // Same-cycle update and lookup: no bypass.
      update(16'h3050, 1, 16'h5000);
      bp.lookup_valid = 1; bp.lookup_pc = 16'h3050;
      probe("no_bypass", 0, 0, 16'h3052); tick();
      lookup(16'h3050); probe("after_update", 1, 1, 16'h5000); tick();

      // Invalidate wins over a same-cycle update.
      update(16'h3060, 1, 16'h6000); bp.invalidate_all = 1; tick();
      lookup(16'h3060); probe("inv_drop", 0, 0, 16'h3062); tick();
      lookup(16'h3050); probe("inv_3050", 0, 0, 16'h3052); tick();
      lookup(16'h3030); probe("inv_3030", 0, 0, 16'h3032); tick();

      // Statistics saturation.
      for (int k = 0; k < 20; k++) begin
         update(16'h7000, 0, 16'h0); bp.update_mispredict = 1; tick();
      end
      for (int k = 0; k < 8; k++) begin lookup(16'h0100 + 16'(2 * k)); tick(); end
      idle();
      #1;
      check("mispredict_sat", 32'(bp.mispredict_count), 32'd15);
      check("lookup_sat", 32'(bp.lookup_count), 32'd15);

      // PC wrap and lookup_valid gating.
      lookup(16'hFFFE); probe("wrap", 0, 0, 16'h0000); tick();
      update(16'h1234, 1, 16'h2000); tick();
      idle(); bp.lookup_pc = 16'h1234; probe("lv_low", 0, 0, 16'h1236); tick();
      lookup(16'h1234); probe("lv_high", 1, 1, 16'h2000); tick();

      // Asynchronous reset between edges, with an update pending.
      lookup(16'h1234);
      bp.update_valid = 1; bp.update_pc = 16'h2222; bp.update_taken = 1; bp.update_target = 16'h9000;
      #2 rst_n = 0;
      model_reset();
      #1;
      check("rst_hit", 32'(bp.hit), 32'd0);
      check("rst_target", 32'(bp.predict_target), 32'h1236);
      check("rst_lookup_count", 32'(bp.lookup_count), 32'd0);
      check("rst_mispredict_count", 32'(bp.mispredict_count), 32'd0);
      tick();
      rst_n = 1;
      lookup(16'h2222); probe("discarded", 0, 0, 16'h2224); tick();
      update(16'h4444, 1, 16'hA000); tick();
      lookup(16'h4444); probe("first_after_reset", 1, 1, 16'hA000); tick();
      idle();
      tick();
      chk_en = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
